// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 scan-code decoder popping bytes from an upstream FIFO
// Optional held-key table and query port: define PS2_KEY_STATE_EN.
module ps2_scancode_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_ready,
  output logic       rdn,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       status_valid,
  output logic [7:0] status_code
`ifdef PS2_KEY_STATE_EN
  ,
  input  logic [7:0] query_code,
  input  logic       query_ext,
  output logic       query_down
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_t;

  state_t     state, state_n;
  logic [2:0] skip, skip_n;
  logic       gap;
  logic       pop;
  logic       kv_n, ke_n, kb_n, sv_n;
  logic [7:0] kc_n, sc_n;

  // gap forces an idle cycle after every pop so in_ready can settle
  assign pop = in_ready && !gap && !rst;
  assign rdn = !pop;

  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'h00, 8'hFF, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    skip_n  = skip;
    kv_n    = 1'b0;
    kc_n    = key_code;
    ke_n    = key_ext;
    kb_n    = key_break;
    sv_n    = 1'b0;
    sc_n    = status_code;
    if (pop) begin
      if (state == S_PAUSE) begin
        skip_n = skip - 3'd1;
        if (skip == 3'd1) begin
          state_n = S_IDLE;
          kv_n    = 1'b1;
          kc_n    = 8'hE1;
          ke_n    = 1'b0;
          kb_n    = 1'b0;
        end
      end else if (in_data == 8'hE0) begin
        if (state == S_IDLE)    state_n = S_E0;
        else if (state == S_F0) state_n = S_E0F0;
      end else if (in_data == 8'hF0) begin
        if (state == S_IDLE)    state_n = S_F0;
        else if (state == S_E0) state_n = S_E0F0;
      end else if (in_data == 8'hE1 && state == S_IDLE) begin
        state_n = S_PAUSE;
        skip_n  = 3'd7;
      end else if (is_status(in_data)) begin
        sv_n    = 1'b1;
        sc_n    = in_data;
        state_n = S_IDLE;
      end else begin
        kv_n    = 1'b1;
        kc_n    = in_data;
        ke_n    = (state == S_E0) || (state == S_E0F0);
        kb_n    = (state == S_F0) || (state == S_E0F0);
        state_n = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      skip         <= 3'd0;
      gap          <= 1'b0;
      key_valid    <= 1'b0;
      key_code     <= 8'h00;
      key_ext      <= 1'b0;
      key_break    <= 1'b0;
      status_valid <= 1'b0;
      status_code  <= 8'h00;
    end else begin
      state        <= state_n;
      skip         <= skip_n;
      gap          <= pop;
      key_valid    <= kv_n;
      key_code     <= kc_n;
      key_ext      <= ke_n;
      key_break    <= kb_n;
      status_valid <= sv_n;
      status_code  <= sc_n;
    end
  end

`ifdef PS2_KEY_STATE_EN
  logic [511:0] held;

  // Pause is the only event reported as E1 with neither prefix flag
  always_ff @(posedge clk) begin
    if (rst)
      held <= '0;
    else if (key_valid && !(key_code == 8'hE1 && !key_ext && !key_break))
      held[{key_ext, key_code}] <= !key_break;
  end

  assign query_down = held[{query_ext, query_code}];
`endif

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have port clk, input, 1, system clock (50 MHz); all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port in_data, input, 8, scan-code byte at the head of the upstream PS/2 receive FIFO.
REQ-004 SHALL have port in_ready, input, 1, high while the upstream FIFO is not empty.
REQ-005 SHALL have port rdn, output, 1, active-low pop strobe to the upstream FIFO.
REQ-006 SHALL have port key_valid, output, 1, one-cycle pulse marking a decoded key event.
REQ-007 SHALL have port key_code, output, 8, final scan-code byte of the event (0xE1 for Pause).
REQ-008 SHALL have port key_ext, output, 1, event was E0-prefixed.
REQ-009 SHALL have port key_break, output, 1, event was F0-prefixed (release).
REQ-010 SHALL have port status_valid, output, 1, one-cycle pulse marking a non-key keyboard byte.
REQ-011 SHALL have port status_code, output, 8, that byte (0x00, 0xFF, 0xAA, 0xEE, 0xFA, 0xFC, 0xFD or 0xFE).
REQ-012 SHALL, with KEY_STATE_EN only, have port query_code, input, 8, key to look up.
REQ-013 SHALL, with KEY_STATE_EN only, have port query_ext, input, 1, extended bit of the looked-up key.
REQ-014 SHALL, with KEY_STATE_EN only, have port query_down, output, 1, key currently held.

Function
REQ-015 SHALL drive rdn low for exactly one cycle when in_ready=1 and no pop occurred in the previous cycle; this cycle is the pop cycle.
REQ-016 SHALL sample in_data in the pop cycle; the mandatory idle cycle after each pop lets in_ready settle; peak rate is 1 byte per 2 cycles.
REQ-017 SHALL implement FSM states IDLE, E0, F0, E0F0, PAUSE.
REQ-018 SHALL make these transitions on 0xE0: IDLE→E0, F0→E0F0, E0/E0F0 unchanged.
REQ-019 SHALL make these transitions on 0xF0: IDLE→F0, E0→E0F0, F0/E0F0 unchanged.
REQ-020 SHALL, on 0xE1 in IDLE, enter PAUSE with skip counter=7; every popped byte decrements the counter and is not decoded.
REQ-021 SHALL, when the PAUSE counter reaches 0, emit key_code=0xE1, key_ext=0, key_break=0 and return to IDLE.
REQ-022 SHALL treat status bytes (REQ-011) in IDLE/E0/F0/E0F0 as follows: pulse status_valid, load status_code, clear key_valid and return to IDLE (any prefix discarded).
REQ-023 SHALL, on any other byte in a non-PAUSE state, pulse key_valid with key_code=byte, key_ext=1 in E0/E0F0, key_break=1 in F0/E0F0, then return to IDLE.
REQ-024 SHALL assert key_valid/status_valid in the cycle after the pop cycle of the final byte (latency 1); the pulses are never simultaneous.
REQ-025 SHALL hold key_code/key_ext/key_break/status_code until the next event of the same kind.
REQ-026 SHALL have no back-pressure: events are not stalled, and the decoder pops whenever in_ready allows.
REQ-027 SHALL not pop while in_ready=0, and SHALL produce no outputs then.

Reset
REQ-028 SHALL, with rst=1, set: FSM=IDLE, PAUSE counter=0, pop-gap flag=0, rdn=1, key_valid=0, status_valid=0, key_code=0, key_ext=0, key_break=0, status_code=0, and all key-state bits=0.
REQ-029 SHALL, when rst is asserted mid-sequence (after E0, F0 or within PAUSE), discard the partial sequence; no event is emitted for it.
REQ-030 SHALL keep rdn=1 in any cycle where rst=1.

Configuration
REQ-031 SHALL use macro PS2_KEY_STATE_EN: when defined, keep a 512-bit held-key table indexed {ext,code}, set on make, clear on break, updated in the key_valid cycle.
REQ-032 SHALL, when PS2_KEY_STATE_EN is defined, make query_down combinational: table[{query_ext,query_code}]; a same-cycle update is seen the next cycle.
REQ-033 SHALL, when PS2_KEY_STATE_EN is defined, not change the table on Pause or status bytes.
REQ-034 SHALL, when PS2_KEY_STATE_EN is undefined, omit query ports and table; all other behaviour is identical.

Verification
REQ-035 SHALL cover: FIFO bytes 0x1C → one key_valid, code 0x1C, ext=0, break=0; rdn low exactly 1 cycle.
REQ-036 SHALL cover: bytes E0,F0,75 → single key_valid with code 0x75, ext=1, break=1; no pulse for prefixes.
REQ-037 SHALL cover: E1,14,77,E1,F0,14,F0,77 → exactly one key_valid with code 0xE1, break=0; nothing else.
REQ-038 SHALL cover: F0 then AA → status_valid with code 0xAA, no key_valid; then 0x1C decodes as make (break=0).
REQ-039 SHALL cover: E0 popped, rst pulsed 1 cycle, then 0x6B → key_valid with code 0x6B, ext=0.
REQ-040 SHALL cover, with PS2_KEY_STATE_EN: 1C then F0,1C → query_down(0x1C,0) reads 1 after the make and 0 after the break; query(0x1C,1) stays 0.
